reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high; rdy  in  1  global enable.
REQ-002 SHALL have ports: alloc_valid  in  1; alloc_kind  in  2  (00 REG, 01 BRANCH, 10 STORE, 11 JALR); alloc_rd  in  5; alloc_pc  in  32; alloc_pred_jump  in  1  (dispatcher's branch prediction).
REQ-003 SHALL have ports: alloc_rob_id  out  5  (id given to the entry allocated this cycle); full_rob  out  1.
REQ-004 SHALL have ports: enable_cdb_rs  in  1; cdb_rs_rob_id  in  5; cdb_rs_value  in  32; cdb_rs_jump  in  1; cdb_rs_pc_next  in  32.
REQ-005 SHALL have ports: enable_cdb_lsb  in  1; cdb_lsb_rob_id  in  5; cdb_lsb_value  in  32.
REQ-006 SHALL have ports: query_j_id, query_k_id  in  5; query_j_ready, query_k_ready  out  1; query_j_value, query_k_value  out  32.
REQ-007 SHALL have ports: commit_reg_en  out  1; commit_rd  out  5; commit_value  out  32; commit_rob_id  out  5; commit_store_en  out  1; mispredict  out  1; mispredict_pc  out  32.

Function
REQ-008 SHALL hold 16 entries, ids 0..15, as a circular buffer (4-bit head and tail pointers, 5-bit count 0..16); id 16 is NON_DEPENDENT.
REQ-009 Each entry SHALL store busy, ready, kind, rd, pc, pred_jump, value, jump, pc_next.
REQ-010 alloc_rob_id SHALL be combinational {1'b0, tail}.
REQ-011 On an edge with rdy=1, alloc_valid=1, mispredict=0 and count<16: entry[tail] busy=1, ready=0, fields written; tail increments mod 16.
REQ-012 An allocation with count=16 SHALL be dropped without any state change.
REQ-013 A CDB write (enable=1, id<16, entry busy) SHALL set ready=1 and store value; an RS write also stores jump and pc_next; ids >=16 or non-busy entries are ignored.
REQ-014 When RS and LSB target the same id in one cycle, RS data SHALL win.
REQ-015 Commit: on an edge with rdy=1, mispredict=0 and entry[head] busy and ready, exactly one entry retires: busy cleared, head increments mod 16; a CDB write arriving that cycle is not committed until the next cycle (minimum 1-cycle CDB-to-commit latency).
REQ-016 The retiring entry SHALL drive commit_rob_id=head; REG and JALR pulse commit_reg_en for one cycle with commit_rd and commit_value, only when rd!=0; STORE pulses commit_store_en for one cycle.
REQ-017 BRANCH retirement SHALL pulse mispredict when jump!=pred_jump, with mispredict_pc = jump ? pc_next : pc+4 (mod 2^32).
REQ-018 JALR retirement SHALL always pulse mispredict with mispredict_pc=pc_next.
REQ-019 On an edge where mispredict=1, the buffer SHALL flush regardless of rdy: all busy cleared, head=tail=count=0, full_rob=0; allocations and CDB writes that cycle are ignored; mispredict returns to 0.
REQ-020 Simultaneous allocate and commit SHALL leave count unchanged.
REQ-021 full_rob SHALL be registered and equal 1 when the post-edge count >=15, giving one cycle of slack for an in-flight allocation.
REQ-022 Query: id=16 SHALL return ready=1, value=0; otherwise ready and value come from entry[id], with ready forced to 0 if the entry is not busy.
REQ-023 With rdy=0, all state SHALL be held except the REQ-019 flush; commit_reg_en and commit_store_en are 0 after that edge.

Reset
REQ-024 With rst=1 at an edge: all entries cleared, head=tail=count=0; all outputs 0 except alloc_rob_id, which follows REQ-010 (0).
REQ-025 rst SHALL take priority over rdy, flush, alloc and commit.

Configuration
REQ-026 With macro ROB_QUERY_BYPASS_EN defined: a query whose id matches a same-cycle CDB write SHALL return ready=1 and that CDB value, with RS before LSB. Without it: queries reflect registered state only.

Verification
REQ-027 Reset, alloc REG rd=5 pc=0x100; RS CDB id0 value 0x2A -> commit_reg_en=1, rd=5, value=0x2A, rob_id=0 exactly one cycle after the CDB.
REQ-028 Alloc 16 entries with no commits -> full_rob=1 after the 15th allocation; the 17th alloc is dropped and tail stays 0.
REQ-029 BRANCH pc=0x200, pred_jump=0; CDB jump=1, pc_next=0x240 -> mispredict=1, mispredict_pc=0x240; next cycle count=0, full_rob=0.
REQ-030 Alloc ids 0 and 1; CDB id1 before id0 -> commits occur in order 0 then 1 on consecutive cycles.
REQ-031 RS and LSB both write id3 with 0x11 and 0x22 in the same cycle -> committed value 0x11; with ROB_QUERY_BYPASS_EN, a query of id3 that cycle returns ready=1, value 0x11.
REQ-032 Hold rdy=0 with head ready -> no commit until rdy=1; a pending mispredict still flushes.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: dispatch, CDB writeback, operand query and commit.
// The ROB side uses the slave modport; the driver of dispatch/CDB uses master.
interface reorder_buffer_if;
    logic        alloc_valid;
    logic [1:0]  alloc_kind;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_pc;
    logic        alloc_pred_jump;
    logic [4:0]  alloc_rob_id;
    logic        full_rob;

    logic        enable_cdb_rs;
    logic [4:0]  cdb_rs_rob_id;
    logic [31:0] cdb_rs_value;
    logic        cdb_rs_jump;
    logic [31:0] cdb_rs_pc_next;
    logic        enable_cdb_lsb;
    logic [4:0]  cdb_lsb_rob_id;
    logic [31:0] cdb_lsb_value;

    logic [4:0]  query_j_id;
    logic [4:0]  query_k_id;
    logic        query_j_ready;
    logic        query_k_ready;
    logic [31:0] query_j_value;
    logic [31:0] query_k_value;

    logic        commit_reg_en;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [4:0]  commit_rob_id;
    logic        commit_store_en;
    logic        mispredict;
    logic [31:0] mispredict_pc;

    modport master (
        output alloc_valid, alloc_kind, alloc_rd,
        output alloc_pc, alloc_pred_jump,
        output enable_cdb_rs, cdb_rs_rob_id,
        output cdb_rs_value, cdb_rs_jump, cdb_rs_pc_next,
        output enable_cdb_lsb, cdb_lsb_rob_id, cdb_lsb_value,
        output query_j_id, query_k_id,
        input  alloc_rob_id, full_rob,
        input  query_j_ready, query_k_ready,
        input  query_j_value, query_k_value,
        input  commit_reg_en, commit_rd, commit_value,
        input  commit_rob_id, commit_store_en,
        input  mispredict, mispredict_pc
    );

    modport slave (
        input  alloc_valid, alloc_kind, alloc_rd,
        input  alloc_pc, alloc_pred_jump,
        input  enable_cdb_rs, cdb_rs_rob_id,
        input  cdb_rs_value, cdb_rs_jump, cdb_rs_pc_next,
        input  enable_cdb_lsb, cdb_lsb_rob_id, cdb_lsb_value,
        input  query_j_id, query_k_id,
        output alloc_rob_id, full_rob,
        output query_j_ready, query_k_ready,
        output query_j_value, query_k_value,
        output commit_reg_en, commit_rd, commit_value,
        output commit_rob_id, commit_store_en,
        output mispredict, mispredict_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// 16-entry in-order-retire reorder buffer with branch/JALR flush.
// Define ROB_QUERY_BYPASS_EN to forward same-cycle CDB data to queries.
module reorder_buffer (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    reorder_buffer_if.slave  bus
);
    typedef enum logic [1:0] {
        K_REG    = 2'b00,
        K_BRANCH = 2'b01,
        K_STORE  = 2'b10,
        K_JALR   = 2'b11
    } kind_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        kind_e       kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred_jump;
        logic [31:0] value;
        logic        jump;
        logic [31:0] pc_next;
    } rob_entry_t;

    rob_entry_t  r_ent [16];
    logic [3:0]  r_head;
    logic [3:0]  r_tail;
    logic [4:0]  r_count;
    logic        r_full;
    logic        r_mispredict;
    logic [31:0] r_mispredict_pc;
    logic        r_commit_reg_en;
    logic        r_commit_store_en;
    logic [4:0]  r_commit_rd;
    logic [31:0] r_commit_value;
    logic [4:0]  r_commit_rob_id;

    rob_entry_t  w_head;
    logic        w_alloc;
    logic        w_commit;
    logic        w_rs_wr;
    logic        w_lsb_wr;
    logic [4:0]  w_count_nxt;
    logic [32:0] w_qj;
    logic [32:0] w_qk;

    assign w_head   = r_ent[r_head];
    assign w_alloc  = rdy && !r_mispredict && bus.alloc_valid
                      && (r_count != 5'd16);
    assign w_commit = rdy && !r_mispredict
                      && w_head.busy && w_head.ready;
    assign w_rs_wr  = rdy && !r_mispredict && bus.enable_cdb_rs
                      && !bus.cdb_rs_rob_id[4]
                      && r_ent[bus.cdb_rs_rob_id[3:0]].busy;
    assign w_lsb_wr = rdy && !r_mispredict && bus.enable_cdb_lsb
                      && !bus.cdb_lsb_rob_id[4]
                      && r_ent[bus.cdb_lsb_rob_id[3:0]].busy;
    assign w_count_nxt = r_count + {4'd0, w_alloc}
                         - {4'd0, w_commit};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_ent[i] <= '0;
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            r_full            <= 1'b0;
            r_mispredict      <= 1'b0;
            r_mispredict_pc   <= '0;
            r_commit_reg_en   <= 1'b0;
            r_commit_store_en <= 1'b0;
            r_commit_rd       <= '0;
            r_commit_value    <= '0;
            r_commit_rob_id   <= '0;
        end else if (r_mispredict) begin
            for (int i = 0; i < 16; i++) begin
                r_ent[i].busy  <= 1'b0;
                r_ent[i].ready <= 1'b0;
            end
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            r_full            <= 1'b0;
            r_mispredict      <= 1'b0;
            r_commit_reg_en   <= 1'b0;
            r_commit_store_en <= 1'b0;
        end else if (rdy) begin
            r_commit_reg_en   <= 1'b0;
            r_commit_store_en <= 1'b0;
            // LSB first so a same-id RS write overrides it
            if (w_lsb_wr) begin
                r_ent[bus.cdb_lsb_rob_id[3:0]].ready <= 1'b1;
                r_ent[bus.cdb_lsb_rob_id[3:0]].value <= bus.cdb_lsb_value;
            end
            if (w_rs_wr) begin
                r_ent[bus.cdb_rs_rob_id[3:0]].ready   <= 1'b1;
                r_ent[bus.cdb_rs_rob_id[3:0]].value   <= bus.cdb_rs_value;
                r_ent[bus.cdb_rs_rob_id[3:0]].jump    <= bus.cdb_rs_jump;
                r_ent[bus.cdb_rs_rob_id[3:0]].pc_next <= bus.cdb_rs_pc_next;
            end
            if (w_commit) begin
                r_ent[r_head].busy <= 1'b0;
                r_head             <= r_head + 4'd1;
                r_commit_rob_id    <= {1'b0, r_head};
                unique case (w_head.kind)
                    K_REG: begin
                        if (w_head.rd != 5'd0) begin
                            r_commit_reg_en <= 1'b1;
                            r_commit_rd     <= w_head.rd;
                            r_commit_value  <= w_head.value;
                        end
                    end
                    K_STORE: r_commit_store_en <= 1'b1;
                    K_BRANCH: begin
                        if (w_head.jump != w_head.pred_jump) begin
                            r_mispredict    <= 1'b1;
                            r_mispredict_pc <= w_head.jump
                                ? w_head.pc_next
                                : w_head.pc + 32'd4;
                        end
                    end
                    K_JALR: begin
                        if (w_head.rd != 5'd0) begin
                            r_commit_reg_en <= 1'b1;
                            r_commit_rd     <= w_head.rd;
                            r_commit_value  <= w_head.value;
                        end
                        r_mispredict    <= 1'b1;
                        r_mispredict_pc <= w_head.pc_next;
                    end
                endcase
            end
            if (w_alloc) begin
                r_ent[r_tail] <= '{
                    busy:      1'b1,
                    ready:     1'b0,
                    kind:      kind_e'(bus.alloc_kind),
                    rd:        bus.alloc_rd,
                    pc:        bus.alloc_pc,
                    pred_jump: bus.alloc_pred_jump,
                    value:     32'd0,
                    jump:      1'b0,
                    pc_next:   32'd0
                };
                r_tail <= r_tail + 4'd1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt >= 5'd15);
        end else begin
            r_commit_reg_en   <= 1'b0;
            r_commit_store_en <= 1'b0;
        end
    end

    function automatic logic [32:0] f_query(
        input logic [4:0] id,
        input rob_entry_t e
    );
        if (id[4]) return {1'b1, 32'd0};
        return {e.busy && e.ready, e.value};
    endfunction

    always_comb begin
        w_qj = f_query(bus.query_j_id, r_ent[bus.query_j_id[3:0]]);
        w_qk = f_query(bus.query_k_id, r_ent[bus.query_k_id[3:0]]);
`ifdef ROB_QUERY_BYPASS_EN
        if (!bus.query_j_id[4]) begin
            if (bus.enable_cdb_lsb
                && bus.cdb_lsb_rob_id == bus.query_j_id)
                w_qj = {1'b1, bus.cdb_lsb_value};
            if (bus.enable_cdb_rs
                && bus.cdb_rs_rob_id == bus.query_j_id)
                w_qj = {1'b1, bus.cdb_rs_value};
        end
        if (!bus.query_k_id[4]) begin
            if (bus.enable_cdb_lsb
                && bus.cdb_lsb_rob_id == bus.query_k_id)
                w_qk = {1'b1, bus.cdb_lsb_value};
            if (bus.enable_cdb_rs
                && bus.cdb_rs_rob_id == bus.query_k_id)
                w_qk = {1'b1, bus.cdb_rs_value};
        end
`endif
    end

    assign bus.alloc_rob_id    = {1'b0, r_tail};
    assign bus.full_rob        = r_full;
    assign bus.query_j_ready   = w_qj[32];
    assign bus.query_j_value   = w_qj[31:0];
    assign bus.query_k_ready   = w_qk[32];
    assign bus.query_k_value   = w_qk[31:0];
    assign bus.commit_reg_en   = r_commit_reg_en;
    assign bus.commit_rd       = r_commit_rd;
    assign bus.commit_value    = r_commit_value;
    assign bus.commit_rob_id   = r_commit_rob_id;
    assign bus.commit_store_en = r_commit_store_en;
    assign bus.mispredict      = r_mispredict;
    assign bus.mispredict_pc   = r_mispredict_pc;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a queue-based reference model
// compared every cycle, plus literal checks for the key scenarios.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    reorder_buffer_if bus ();

    reorder_buffer dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  id;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred;
        logic        rdy_f;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pcn;
    } m_ent_t;

    m_ent_t      m_q[$];
    logic [3:0]  m_tail;
    logic        e_reg_en, e_st_en, e_misp, e_full;
    logic [4:0]  e_rd, e_rob_id;
    logic [31:0] e_val, e_mpc;
    bit          m_on = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain in-order queue of live entries.
    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_tail = 4'd0;
            e_reg_en = 0; e_st_en = 0; e_misp = 0; e_full = 0;
            e_rd = 0; e_rob_id = 0; e_val = 0; e_mpc = 0;
        end else if (e_misp) begin
            m_q.delete();
            m_tail = 4'd0;
            e_full = 0; e_misp = 0; e_reg_en = 0; e_st_en = 0;
        end else if (!rdy) begin
            e_reg_en = 0;
            e_st_en = 0;
        end else begin
            int     n0;
            bit     cm;
            m_ent_t h;
            m_ent_t nw;
            n0 = m_q.size();
            cm = (n0 > 0) && m_q[0].rdy_f;
            e_reg_en = 0;
            e_st_en = 0;
            foreach (m_q[i]) begin
                if (bus.enable_cdb_lsb && bus.cdb_lsb_rob_id == m_q[i].id) begin
                    m_q[i].rdy_f = 1;
                    m_q[i].val = bus.cdb_lsb_value;
                end
                if (bus.enable_cdb_rs && bus.cdb_rs_rob_id == m_q[i].id) begin
                    m_q[i].rdy_f = 1;
                    m_q[i].val = bus.cdb_rs_value;
                    m_q[i].jump = bus.cdb_rs_jump;
                    m_q[i].pcn = bus.cdb_rs_pc_next;
                end
            end
            if (cm) begin
                h = m_q.pop_front();
                e_rob_id = h.id;
                if ((h.kind == 2'd0 || h.kind == 2'd3) && h.rd != 0) begin
                    e_reg_en = 1;
                    e_rd = h.rd;
                    e_val = h.val;
                end
                if (h.kind == 2'd2) e_st_en = 1;
                if (h.kind == 2'd1 && h.jump != h.pred) begin
                    e_misp = 1;
                    e_mpc = h.jump ? h.pcn : h.pc + 32'd4;
                end
                if (h.kind == 2'd3) begin
                    e_misp = 1;
                    e_mpc = h.pcn;
                end
            end
            if (bus.alloc_valid && n0 < 16) begin
                nw.id = {1'b0, m_tail};
                nw.kind = bus.alloc_kind;
                nw.rd = bus.alloc_rd;
                nw.pc = bus.alloc_pc;
                nw.pred = bus.alloc_pred_jump;
                nw.rdy_f = 0;
                nw.val = 0;
                nw.jump = 0;
                nw.pcn = 0;
                m_q.push_back(nw);
                m_tail = m_tail + 4'd1;
            end
            e_full = (m_q.size() >= 15);
        end
    end

    function automatic logic [32:0] m_query(input logic [4:0] id);
        logic [32:0] r = 33'd0;
        if (id[4]) return {1'b1, 32'd0};
        foreach (m_q[i])
            if (m_q[i].id == id) r = {m_q[i].rdy_f, m_q[i].val};
`ifdef ROB_QUERY_BYPASS_EN
        if (bus.enable_cdb_lsb && bus.cdb_lsb_rob_id == id)
            r = {1'b1, bus.cdb_lsb_value};
        if (bus.enable_cdb_rs && bus.cdb_rs_rob_id == id)
            r = {1'b1, bus.cdb_rs_value};
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (m_on) begin
            logic [32:0] qj;
            logic [32:0] qk;
            chk("commit_reg_en", 32'(bus.commit_reg_en), 32'(e_reg_en));
            chk("commit_store_en", 32'(bus.commit_store_en), 32'(e_st_en));
            chk("commit_rd", 32'(bus.commit_rd), 32'(e_rd));
            chk("commit_value", bus.commit_value, e_val);
            chk("commit_rob_id", 32'(bus.commit_rob_id), 32'(e_rob_id));
            chk("mispredict", 32'(bus.mispredict), 32'(e_misp));
            chk("mispredict_pc", bus.mispredict_pc, e_mpc);
            chk("full_rob", 32'(bus.full_rob), 32'(e_full));
            chk("alloc_rob_id", 32'(bus.alloc_rob_id), {28'd0, m_tail});
            qj = m_query(bus.query_j_id);
            qk = m_query(bus.query_k_id);
            chk("query_j_ready", 32'(bus.query_j_ready), 32'(qj[32]));
            chk("query_k_ready", 32'(bus.query_k_ready), 32'(qk[32]));
            if (qj[32]) chk("query_j_value", bus.query_j_value, qj[31:0]);
            if (qk[32]) chk("query_k_value", bus.query_k_value, qk[31:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.alloc_valid = 0;
        bus.enable_cdb_rs = 0;
        bus.enable_cdb_lsb = 0;
    endtask

    task automatic alloc(input logic [1:0] k, input logic [4:0] rd,
                         input logic [31:0] pc, input logic pj);
        bus.alloc_valid = 1;
        bus.alloc_kind = k;
        bus.alloc_rd = rd;
        bus.alloc_pc = pc;
        bus.alloc_pred_jump = pj;
    endtask

    task automatic rs(input logic [4:0] id, input logic [31:0] v,
                      input logic j, input logic [31:0] pn);
        bus.enable_cdb_rs = 1;
        bus.cdb_rs_rob_id = id;
        bus.cdb_rs_value = v;
        bus.cdb_rs_jump = j;
        bus.cdb_rs_pc_next = pn;
    endtask

    task automatic lsb(input logic [4:0] id, input logic [31:0] v);
        bus.enable_cdb_lsb = 1;
        bus.cdb_lsb_rob_id = id;
        bus.cdb_lsb_value = v;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        m_on = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        rdy = 1;
        bus.alloc_valid = 0; bus.alloc_kind = 0; bus.alloc_rd = 0;
        bus.alloc_pc = 0; bus.alloc_pred_jump = 0;
        bus.enable_cdb_rs = 0; bus.cdb_rs_rob_id = 0;
        bus.cdb_rs_value = 0; bus.cdb_rs_jump = 0; bus.cdb_rs_pc_next = 0;
        bus.enable_cdb_lsb = 0; bus.cdb_lsb_rob_id = 0;
        bus.cdb_lsb_value = 0;
        bus.query_j_id = 5'd16;
        bus.query_k_id = 5'd16;

        do_reset();
        chk("rst full_rob", 32'(bus.full_rob), 32'd0);
        chk("rst alloc_rob_id", 32'(bus.alloc_rob_id), 32'd0);
        chk("rst commit_reg_en", 32'(bus.commit_reg_en), 32'd0);
        chk("rst mispredict", 32'(bus.mispredict), 32'd0);
        chk("rst query16 ready", 32'(bus.query_j_ready), 32'd1);

        // basic REG commit one cycle after CDB
        bus.query_j_id = 5'd0;
        alloc(2'd0, 5'd5, 32'h100, 0); tick();
        rs(5'd0, 32'h2A, 0, 32'h0); tick();
        chk("cdb q0 ready", 32'(bus.query_j_ready), 32'd1);
        chk("cdb q0 value", bus.query_j_value, 32'h2A);
        chk("no early commit", 32'(bus.commit_reg_en), 32'd0);
        tick();
        chk("c0 reg_en", 32'(bus.commit_reg_en), 32'd1);
        chk("c0 rd", 32'(bus.commit_rd), 32'd5);
        chk("c0 value", bus.commit_value, 32'h2A);
        chk("c0 rob_id", 32'(bus.commit_rob_id), 32'd0);
        chk("q0 after retire", 32'(bus.query_j_ready), 32'd0);
        tick();
        chk("c0 pulse end", 32'(bus.commit_reg_en), 32'd0);

        // fill to 16, drop the 17th, then drain with overlapping allocs
        do_reset();
        bus.query_k_id = 5'd3;
        for (int i = 0; i < 17; i++) begin
            alloc(2'd0, 5'(i + 1), 32'h1000 + 32'(4 * i), 0);
            tick();
            if (i == 13) chk("full after 14", 32'(bus.full_rob), 32'd0);
            if (i == 14) chk("full after 15", 32'(bus.full_rob), 32'd1);
        end
        chk("17th dropped tail", 32'(bus.alloc_rob_id), 32'd0);
        chk("17th full", 32'(bus.full_rob), 32'd1);
        for (int i = 0; i < 16; i++) begin
            rs(5'(i), 32'(i * 3 + 1), 0, 32'h0);
            if (i < 4) alloc(2'd0, 5'd20, 32'h2000, 0);
            tick();
        end
        tick(); tick();

        // branch mispredict flushes younger work
        do_reset();
        bus.query_j_id = 5'd1;
        alloc(2'd1, 5'd0, 32'h200, 0); tick();
        alloc(2'd0, 5'd3, 32'h204, 0); tick();
        rs(5'd0, 32'h0, 1, 32'h240); tick();
        tick();
        chk("br mispredict", 32'(bus.mispredict), 32'd1);
        chk("br mispredict_pc", bus.mispredict_pc, 32'h240);
        alloc(2'd0, 5'd4, 32'h208, 0);
        rs(5'd1, 32'h55, 0, 32'h0);
        tick();
        chk("flush mispredict", 32'(bus.mispredict), 32'd0);
        chk("flush full", 32'(bus.full_rob), 32'd0);
        chk("flush tail", 32'(bus.alloc_rob_id), 32'd0);
        chk("flush q1", 32'(bus.query_j_ready), 32'd0);

        alloc(2'd1, 5'd0, 32'h300, 1); tick();
        rs(5'd0, 32'h0, 1, 32'h380); tick(); tick();
        chk("br correct", 32'(bus.mispredict), 32'd0);
        alloc(2'd1, 5'd0, 32'hFFFF_FFFC, 1); tick();
        rs(5'd1, 32'h0, 0, 32'h1234); tick(); tick();
        chk("br nt mispredict", 32'(bus.mispredict), 32'd1);
        chk("br pc+4 wrap", bus.mispredict_pc, 32'h0);
        tick();

        alloc(2'd3, 5'd1, 32'h400, 0); tick();
        rs(5'd0, 32'h404, 0, 32'h500); tick(); tick();
        chk("jalr reg_en", 32'(bus.commit_reg_en), 32'd1);
        chk("jalr value", bus.commit_value, 32'h404);
        chk("jalr mispredict", 32'(bus.mispredict), 32'd1);
        chk("jalr pc", bus.mispredict_pc, 32'h500);
        tick();

        alloc(2'd0, 5'd0, 32'h500, 0); tick();
        rs(5'd0, 32'h77, 0, 32'h0); tick(); tick();
        chk("rd0 no reg_en", 32'(bus.commit_reg_en), 32'd0);
        alloc(2'd2, 5'd0, 32'h600, 0); tick();
        lsb(5'd1, 32'hBEEF); tick(); tick();
        chk("store_en", 32'(bus.commit_store_en), 32'd1);
        chk("store rob_id", 32'(bus.commit_rob_id), 32'd1);
        tick();
        chk("store pulse end", 32'(bus.commit_store_en), 32'd0);

        // out-of-order completion retires in order
        do_reset();
        alloc(2'd0, 5'd7, 32'h10, 0); tick();
        alloc(2'd0, 5'd8, 32'h14, 0); tick();
        rs(5'd1, 32'h77, 0, 32'h0); tick();
        chk("ooo no commit1", 32'(bus.commit_reg_en), 32'd0);
        rs(5'd0, 32'h66, 0, 32'h0); tick();
        chk("ooo no commit0", 32'(bus.commit_reg_en), 32'd0);
        tick();
        chk("ooo first id", 32'(bus.commit_rob_id), 32'd0);
        chk("ooo first val", bus.commit_value, 32'h66);
        tick();
        chk("ooo second id", 32'(bus.commit_rob_id), 32'd1);
        chk("ooo second val", bus.commit_value, 32'h77);
        chk("ooo second en", 32'(bus.commit_reg_en), 32'd1);

        // RS beats LSB on the same id
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc(2'd0, 5'(10 + i), 32'h40, 0);
            tick();
        end
        bus.query_j_id = 5'd3;
        rs(5'd3, 32'h11, 0, 32'h0);
        lsb(5'd3, 32'h22);
        #1;
`ifdef ROB_QUERY_BYPASS_EN
        chk("bypass ready", 32'(bus.query_j_ready), 32'd1);
        chk("bypass value", bus.query_j_value, 32'h11);
`else
        chk("no bypass ready", 32'(bus.query_j_ready), 32'd0);
`endif
        tick();
        chk("rs wins query", bus.query_j_value, 32'h11);
        for (int i = 0; i < 3; i++) begin
            rs(5'(i), 32'h90 + 32'(i), 0, 32'h0);
            tick();
        end
        tick(); tick();
        chk("rs wins rob_id", 32'(bus.commit_rob_id), 32'd3);
        chk("rs wins value", bus.commit_value, 32'h11);

        // rdy stalls commit but not a pending flush
        do_reset();
        alloc(2'd0, 5'd9, 32'h80, 0); tick();
        rs(5'd0, 32'h99, 0, 32'h0); tick();
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall no commit", 32'(bus.commit_reg_en), 32'd0);
        end
        rdy = 1;
        tick();
        chk("unstall commit", 32'(bus.commit_reg_en), 32'd1);
        chk("unstall value", bus.commit_value, 32'h99);
        alloc(2'd1, 5'd0, 32'h700, 0); tick();
        rs(5'd1, 32'h0, 1, 32'h780); tick(); tick();
        chk("stall br misp", 32'(bus.mispredict), 32'd1);
        rdy = 0;
        tick();
        chk("flush under stall", 32'(bus.mispredict), 32'd0);
        chk("flush stall tail", 32'(bus.alloc_rob_id), 32'd0);
        rdy = 1;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
